// File: rtl/sha256_multiblock_hasher.sv
// Runtime-length SHA-256 over a single-port word memory: reads, pads, hashes N blocks, writes digest.
// Optional SHA-224 output mode when SHA256_SHA224_MODE_EN is defined (adds the sha224 port).
module sha256_multiblock_hasher #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  msg_len,
  input  logic [ADDR_W-1:0] message_addr,
  input  logic [ADDR_W-1:0] output_addr,
`ifdef SHA256_SHA224_MODE_EN
  input  logic              sha224,
`endif
  output logic              done,
  output logic              mem_clk,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  localparam int BLK_W = LEN_W - 2;
  localparam int T_W   = LEN_W + 2;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [31:0] IV256 [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
`ifdef SHA256_SHA224_MODE_EN
  localparam logic [31:0] IV224 [0:7] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
`endif

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, ADD, WRITE} state_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  state_t            state_q, state_d;
  logic [31:0]       h_r [0:7];
  logic [31:0]       v_r [0:7];
  logic [31:0]       w_r [0:15];
  logic [31:0]       iv  [0:7];
  logic [6:0]        cnt;
  logic [BLK_W-1:0]  blk, last_blk;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W:0]    len_p2;
  logic [ADDR_W-1:0] msg_addr_r, out_addr_r;
  logic [2:0]        wr_last;
  logic [3:0]        cap_k;
  logic [T_W-1:0]    t_rd, t_cap, len_ext;
  logic [63:0]       bitlen;
  logic [31:0]       load_word, w_new, t1, t2;
  logic              rd_active, final_blk;

`ifdef SHA256_SHA224_MODE_EN
  logic sel224;
  assign wr_last = sel224 ? 3'd6 : 3'd7;
  always_comb for (int i = 0; i < 8; i++) iv[i] = sha224 ? IV224[i] : IV256[i];
`else
  assign wr_last = 3'd7;
  always_comb for (int i = 0; i < 8; i++) iv[i] = IV256[i];
`endif

  assign mem_clk   = clk;
  assign len_p2    = {1'b0, msg_len} + (LEN_W+1)'(2);
  assign len_ext   = T_W'(len_r);
  assign bitlen    = 64'(len_r) << 5;
  assign final_blk = (blk == last_blk);
  // Word k of the block is addressed in LOAD cycle k and captured one cycle later.
  assign t_rd      = {blk, cnt[3:0]};
  assign cap_k     = cnt[3:0] - 4'd1;
  assign t_cap     = {blk, cap_k};
  assign rd_active = (state_q == LOAD) && !cnt[4] && (t_rd < len_ext);

  always_comb begin
    load_word = 32'h0;
    if (t_cap < len_ext)                  load_word = mem_read_data;
    else if (t_cap == len_ext)            load_word = 32'h8000_0000;
    else if (final_blk && cap_k == 4'd14) load_word = bitlen[63:32];
    else if (final_blk && cap_k == 4'd15) load_word = bitlen[31:0];
  end

  always_comb begin
    t1 = v_r[7] + (rotr(v_r[4], 6) ^ rotr(v_r[4], 11) ^ rotr(v_r[4], 25))
       + ((v_r[4] & v_r[5]) ^ (~v_r[4] & v_r[6])) + K[cnt[5:0]] + w_r[0];
    t2 = (rotr(v_r[0], 2) ^ rotr(v_r[0], 13) ^ rotr(v_r[0], 22))
       + ((v_r[0] & v_r[1]) ^ (v_r[0] & v_r[2]) ^ (v_r[1] & v_r[2]));
    w_new = (rotr(w_r[14], 17) ^ rotr(w_r[14], 19) ^ (w_r[14] >> 10)) + w_r[9]
          + (rotr(w_r[1], 7) ^ rotr(w_r[1], 18) ^ (w_r[1] >> 3)) + w_r[0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_write_data = 32'h0;
    unique case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD: begin
        if (rd_active) mem_addr = msg_addr_r + ADDR_W'(t_rd);
        if (cnt == 7'd16) state_d = COMPUTE;
      end
      COMPUTE: if (cnt == 7'd63) state_d = ADD;
      ADD:     state_d = final_blk ? WRITE : LOAD;
      WRITE: begin
        mem_we         = 1'b1;
        mem_addr       = out_addr_r + ADDR_W'(cnt[2:0]);
        mem_write_data = h_r[cnt[2:0]];
        if (cnt[2:0] == wr_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // done trails the state by one cycle so it rises only once IDLE is settled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) done <= 1'b1;
    else          done <= (state_q == IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      blk        <= '0;
      last_blk   <= '0;
      len_r      <= '0;
      msg_addr_r <= '0;
      out_addr_r <= '0;
`ifdef SHA256_SHA224_MODE_EN
      sel224     <= 1'b0;
`endif
      for (int i = 0; i < 8; i++) begin
        h_r[i] <= 32'h0;
        v_r[i] <= 32'h0;
      end
      for (int i = 0; i < 16; i++) w_r[i] <= 32'h0;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          len_r      <= msg_len;
          last_blk   <= BLK_W'(len_p2 >> 4);
          msg_addr_r <= message_addr;
          out_addr_r <= output_addr;
`ifdef SHA256_SHA224_MODE_EN
          sel224     <= sha224;
`endif
          blk        <= '0;
          cnt        <= '0;
          for (int i = 0; i < 8; i++) begin
            h_r[i] <= iv[i];
            v_r[i] <= iv[i];
          end
        end
        LOAD: begin
          if (cnt != 7'd0) begin
            for (int i = 0; i < 15; i++) w_r[i] <= w_r[i+1];
            w_r[15] <= load_word;
          end
          cnt <= (cnt == 7'd16) ? 7'd0 : cnt + 7'd1;
        end
        COMPUTE: begin
          for (int i = 0; i < 15; i++) w_r[i] <= w_r[i+1];
          w_r[15] <= w_new;
          v_r[0] <= t1 + t2;
          v_r[1] <= v_r[0];
          v_r[2] <= v_r[1];
          v_r[3] <= v_r[2];
          v_r[4] <= v_r[3] + t1;
          v_r[5] <= v_r[4];
          v_r[6] <= v_r[5];
          v_r[7] <= v_r[6];
          cnt <= (cnt == 7'd63) ? 7'd0 : cnt + 7'd1;
        end
        ADD: begin
          for (int i = 0; i < 8; i++) begin
            h_r[i] <= h_r[i] + v_r[i];
            v_r[i] <= h_r[i] + v_r[i];
          end
          blk <= blk + BLK_W'(1);
        end
        WRITE:   cnt <= cnt + 7'd1;
        default: cnt <= '0;
      endcase
    end
  end

endmodule
